// File: rtl/song_reader.sv
// song_reader: sequencer that walks a per-song note ROM and hands notes to the
// note player one at a time, waiting for note_done between notes.
// Optional feature macro: SONG_LOOP_EN (when defined, the song restarts from
// note 0 after its end instead of parking in END).
module song_reader #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int ADDR_W = 5,
  parameter int SONG_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [SONG_W-1:0]        song,
  input  logic                     restart,
  output logic [SONG_W+ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  output logic [NOTE_W-1:0]        note,
  output logic [DUR_W-1:0]         duration,
  output logic                     new_note,
  input  logic                     note_done,
  output logic                     song_done,
  output logic                     active
);

  localparam logic [ADDR_W-1:0] IDX_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_DONE,
    S_END
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          idx_q, idx_d;
  logic [SONG_W-1:0]          song_q, song_d;
  logic [SONG_W+ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0]          note_q, note_d;
  logic [DUR_W-1:0]           dur_q, dur_d;
  logic                       new_note_q, new_note_d;
  logic                       song_done_q, song_done_d;
  logic                       active_q, active_d;

  logic [NOTE_W-1:0]          rom_note;
  logic [DUR_W-1:0]           rom_dur;
  logic [ADDR_W-1:0]          idx_inc;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];
  assign idx_inc  = idx_q + 1'b1;

  // Next-state and output computation; restart overrides everything last.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    song_d      = song_q;
    rom_addr_d  = rom_addr_q;
    note_d      = note_q;
    dur_d       = dur_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Song select is captured only here; later changes wait for restart.
        if (play) begin
          song_d     = song;
          rom_addr_d = {song, idx_q};
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        // ROM address is already registered; pausing just holds it here.
        if (play) state_d = S_WAIT;
      end
      S_WAIT: begin
        // ROM data is valid now; zero duration terminates the song.
        if (rom_dur == '0) begin
          state_d = S_DONE;
        end else begin
          note_d     = rom_note;
          dur_d      = rom_dur;
          new_note_d = 1'b1;
          state_d    = S_PLAY;
        end
      end
      S_PLAY: begin
        // While paused the player owns timing, so stay put with outputs held.
        if (play && note_done) begin
          if (idx_q == IDX_MAX) begin
            state_d = S_DONE;
          end else begin
            idx_d      = idx_inc;
            rom_addr_d = {song_q, idx_inc};
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        song_done_d = 1'b1;
        idx_d       = '0;
`ifdef SONG_LOOP_EN
        rom_addr_d  = {song_q, {ADDR_W{1'b0}}};
        state_d     = S_FETCH;
`else
        state_d     = S_END;
`endif
      end
      S_END: begin
        // Parked until restart or reset.
        state_d = S_END;
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d     = S_IDLE;
      idx_d       = '0;
      song_d      = '0;
      rom_addr_d  = '0;
      note_d      = '0;
      dur_d       = '0;
      new_note_d  = 1'b0;
      song_done_d = 1'b0;
    end

    active_d = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_PLAY);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      song_q      <= '0;
      rom_addr_q  <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      song_q      <= song_d;
      rom_addr_q  <= rom_addr_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
      active_q    <= active_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign note      = note_q;
  assign duration  = dur_q;
  assign new_note  = new_note_q;
  assign song_done = song_done_q;
  assign active    = active_q;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader with a synchronous ROM model.
module tb_song_reader;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        restart;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        note_done;
  logic        song_done;
  logic        active;

  int checks;
  int failures;

  logic [11:0] rom [128];

  song_reader dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .song     (song),
    .restart  (restart),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .note     (note),
    .duration (duration),
    .new_note (new_note),
    .note_done(note_done),
    .song_done(song_done),
    .active   (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] s1_note(input int i);
    return 6'((i * 7 + 3) & 63);
  endfunction

  function automatic logic [5:0] s1_dur(input int i);
    return 6'(i + 1);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (rom_addr !== 7'h00 || note !== 6'h00 || duration !== 6'h00 ||
        new_note !== 1'b0 || song_done !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("FAIL reset: addr=%h note=%h dur=%h nn=%b sd=%b act=%b, want all 0",
               rom_addr, note, duration, new_note, song_done, active);
    end
  endtask

  task automatic test_first_note();
    song = 2'd2;
    play = 1'b1;
    tick();
    checks++;
    if (rom_addr !== 7'h40 || active !== 1'b1 || new_note !== 1'b0) begin
      failures++;
      $display("FAIL first_fetch: addr=%h act=%b nn=%b, want 40 1 0", rom_addr, active, new_note);
    end
    tick();
    checks++;
    if (new_note !== 1'b0) begin
      failures++;
      $display("FAIL first_early: new_note=%b want 0", new_note);
    end
    tick();
    checks++;
    if (new_note !== 1'b1 || note !== 6'h2A || duration !== 6'd5) begin
      failures++;
      $display("FAIL first_note: nn=%b note=%h dur=%0d, want 1 2a 5", new_note, note, duration);
    end
    tick();
    checks++;
    if (new_note !== 1'b0 || note !== 6'h2A || duration !== 6'd5) begin
      failures++;
      $display("FAIL first_hold: nn=%b note=%h dur=%0d, want 0 2a 5", new_note, note, duration);
    end
  endtask

  task automatic test_next_note();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    checks++;
    if (rom_addr !== 7'h41 || new_note !== 1'b0) begin
      failures++;
      $display("FAIL next_addr: addr=%h nn=%b, want 41 0", rom_addr, new_note);
    end
    tick();
    tick();
    checks++;
    if (new_note !== 1'b1 || note !== 6'h11 || duration !== 6'd9) begin
      failures++;
      $display("FAIL next_note: nn=%b note=%h dur=%0d, want 1 11 9", new_note, note, duration);
    end
  endtask

  task automatic test_pause();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    play = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (new_note !== 1'b0 || rom_addr !== 7'h42 || active !== 1'b1) begin
        failures++;
        $display("FAIL pause_stall[%0d]: nn=%b addr=%h act=%b, want 0 42 1",
                 i, new_note, rom_addr, active);
      end
    end
    play = 1'b1;
    tick();
    checks++;
    if (new_note !== 1'b0) begin
      failures++;
      $display("FAIL pause_resume_early: nn=%b want 0", new_note);
    end
    tick();
    checks++;
    if (new_note !== 1'b1 || note !== 6'h3F || duration !== 6'd1) begin
      failures++;
      $display("FAIL pause_resume: nn=%b note=%h dur=%0d, want 1 3f 1", new_note, note, duration);
    end
  endtask

  task automatic test_song_end();
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    tick();
    tick();
    checks++;
    if (new_note !== 1'b0 || song_done !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("FAIL end_done_state: nn=%b sd=%b act=%b, want 0 0 0", new_note, song_done, active);
    end
    tick();
    checks++;
`ifdef SONG_LOOP_EN
    if (song_done !== 1'b1 || new_note !== 1'b0 || rom_addr !== 7'h40 || active !== 1'b1) begin
      failures++;
      $display("FAIL end_pulse: sd=%b nn=%b addr=%h act=%b, want 1 0 40 1",
               song_done, new_note, rom_addr, active);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
`else
    if (song_done !== 1'b1 || new_note !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("FAIL end_pulse: sd=%b nn=%b act=%b, want 1 0 0", song_done, new_note, active);
    end
    for (int i = 0; i < 6; i++) begin
      note_done = i[0];
      tick();
      checks++;
      if (song_done !== 1'b0 || new_note !== 1'b0 || active !== 1'b0) begin
        failures++;
        $display("FAIL end_quiet[%0d]: sd=%b nn=%b act=%b, want 0 0 0",
                 i, song_done, new_note, active);
      end
    end
    note_done = 1'b0;
`endif
  endtask

  task automatic test_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    song = 2'd2;
    play = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (new_note !== 1'b1 || note !== 6'h2A) begin
      failures++;
      $display("FAIL restart_setup: nn=%b note=%h, want 1 2a", new_note, note);
    end
    restart = 1'b1;
    note_done = 1'b1;
    tick();
    restart = 1'b0;
    note_done = 1'b0;
    checks++;
    if (note !== 6'h00 || duration !== 6'h00 || rom_addr !== 7'h00 ||
        active !== 1'b0 || new_note !== 1'b0 || song_done !== 1'b0) begin
      failures++;
      $display("FAIL restart_clear: note=%h dur=%h addr=%h act=%b nn=%b sd=%b, want all 0",
               note, duration, rom_addr, active, new_note, song_done);
    end
    song = 2'd1;
    tick();
    checks++;
    if (rom_addr !== 7'h20 || active !== 1'b1) begin
      failures++;
      $display("FAIL restart_song1: addr=%h act=%b, want 20 1", rom_addr, active);
    end
    song = 2'd3;
    tick();
    tick();
    checks++;
    if (new_note !== 1'b1 || note !== s1_note(0) || duration !== s1_dur(0)) begin
      failures++;
      $display("FAIL restart_note0: nn=%b note=%h dur=%0d, want 1 %h %0d",
               new_note, note, duration, s1_note(0), s1_dur(0));
    end
  endtask

  // Entered at the new_note cycle of entry 0 of song 1.
  task automatic test_full_song();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (new_note !== 1'b1 || note !== s1_note(i) || duration !== s1_dur(i)) begin
        failures++;
        $display("FAIL full_note[%0d]: nn=%b note=%h dur=%0d, want 1 %h %0d",
                 i, new_note, note, duration, s1_note(i), s1_dur(i));
      end
      note_done = 1'b1;
      tick();
      note_done = 1'b0;
      if (i < 31) begin
        checks++;
        if (rom_addr !== 7'(32 + i + 1)) begin
          failures++;
          $display("FAIL full_addr[%0d]: addr=%h want %h", i, rom_addr, 7'(32 + i + 1));
        end
        tick();
        tick();
      end
    end
    tick();
    checks++;
`ifdef SONG_LOOP_EN
    if (song_done !== 1'b1 || rom_addr !== 7'h20 || active !== 1'b1 || new_note !== 1'b0) begin
      failures++;
      $display("FAIL full_loop_pulse: sd=%b addr=%h act=%b nn=%b, want 1 20 1 0",
               song_done, rom_addr, active, new_note);
    end
    tick();
    tick();
    checks++;
    if (new_note !== 1'b1 || note !== s1_note(0) || song_done !== 1'b0) begin
      failures++;
      $display("FAIL full_loop_resume: nn=%b note=%h sd=%b, want 1 %h 0",
               new_note, note, song_done, s1_note(0));
    end
`else
    if (song_done !== 1'b1 || active !== 1'b0 || new_note !== 1'b0 || rom_addr !== 7'h3F) begin
      failures++;
      $display("FAIL full_end_pulse: sd=%b act=%b nn=%b addr=%h, want 1 0 0 3f",
               song_done, active, new_note, rom_addr);
    end
    for (int i = 0; i < 4; i++) begin
      note_done = ~i[0];
      tick();
      checks++;
      if (song_done !== 1'b0 || new_note !== 1'b0 || active !== 1'b0 || rom_addr !== 7'h3F) begin
        failures++;
        $display("FAIL full_end_quiet[%0d]: sd=%b nn=%b act=%b addr=%h, want 0 0 0 3f",
                 i, song_done, new_note, active, rom_addr);
      end
    end
    note_done = 1'b0;
`endif
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    play      = 1'b0;
    song      = 2'd0;
    restart   = 1'b0;
    note_done = 1'b0;
    for (int a = 0; a < 128; a++) rom[a] = 12'h000;
    rom[7'h40] = {6'h2A, 6'd5};
    rom[7'h41] = {6'h11, 6'd9};
    rom[7'h42] = {6'h3F, 6'd1};
    rom[7'h43] = {6'h07, 6'd0};
    for (int i = 0; i < 32; i++) rom[32 + i] = {s1_note(i), s1_dur(i)};

    test_reset();
    test_first_note();
    test_next_note();
    test_pause();
    test_song_end();
    test_restart();
    test_full_song();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
